// File: rtl/spiker_adapter_reg_pkg.sv
// Register-file types shared by the spiker adapter: reg2hw view of the spike input
// words plus the start/err_clear strobes, and the reader FSM state encoding.
package spiker_adapter_reg_pkg;

    localparam int SPK_WIDTH    = 32;
    localparam int SPK_N_SPIKES = 784;
    localparam int SPK_N_IN_REG = 25;
    localparam int SPK_DATA_W   = 800;

    typedef struct packed {
        logic [SPK_WIDTH-1:0] q;
        logic                 qe;
    } reg2hw_spikes_input_reg_t;

    typedef struct packed {
        logic q;
        logic qe;
    } reg2hw_start_reg_t;

    typedef struct packed {
        logic q;
        logic qe;
    } reg2hw_err_clear_reg_t;

    typedef struct packed {
        reg2hw_spikes_input_reg_t [SPK_N_IN_REG-1:0] spikes_input;
        reg2hw_start_reg_t                           start;
        reg2hw_err_clear_reg_t                       err_clear;
    } reg2hw_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_SEND
    } spiker_rd_state_e;

endpackage

// File: rtl/spiker_word_stager.sv
// Staging registers for the software-written spike words, with a written-word mask
// that tracks which words are fresh since the last snapshot.
module spiker_word_stager #(
    parameter int WIDTH = 32,
    parameter int N_REG = 25,
    parameter int CNT_W = $clog2(N_REG + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REG-1:0]            word_we,
    input  logic [N_REG-1:0][WIDTH-1:0] word_data,
    input  logic                        load,
    output logic [N_REG-1:0][WIDTH-1:0] staging,
    output logic                        mask_full_next,
    output logic [CNT_W-1:0]            words_pending
);

    logic [N_REG-1:0] mask;
    logic [N_REG-1:0] mask_next;
    logic [CNT_W-1:0] written_cnt;

    assign mask_next      = mask | word_we;
    assign mask_full_next = &mask_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            staging <= '0;
            mask    <= '0;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                if (word_we[i]) staging[i] <= word_data[i];
            end
            // A snapshot consumes the mask, but words landing in the same cycle
            // belong to the next vector and must stay marked.
            mask <= load ? word_we : mask_next;
        end
    end

    always_comb begin
        written_cnt = '0;
        for (int i = 0; i < N_REG; i++) begin
            written_cnt = written_cnt + CNT_W'(mask[i]);
        end
    end

    assign words_pending = CNT_W'(N_REG) - written_cnt;

endmodule

// File: rtl/spiker_reader.sv
// Assembles the staged spike words into one core input vector and hands it to the
// spiker core over valid/ready; reports progress and sticky errors for hw2reg.
module spiker_reader
    import spiker_adapter_reg_pkg::*;
#(
    parameter int WIDTH      = SPK_WIDTH,
    parameter int N_SPIKES   = SPK_N_SPIKES,
    parameter int N_REG      = SPK_N_IN_REG,
    parameter int DATA_WIDTH = SPK_DATA_W
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  reg2hw_t                    reg_file_to_ip,
    output logic [DATA_WIDTH-1:0]      data_in_o,
    output logic                       data_valid_o,
    input  logic                       core_ready_i,
    output logic                       busy_o,
    output logic [$clog2(N_REG+1)-1:0] words_pending_o,
    output logic                       err_incomplete_o,
    output logic                       err_overrun_o
);

    localparam int CNT_W = $clog2(N_REG + 1);

    spiker_rd_state_e              state;
    logic [N_REG-1:0]              word_we;
    logic [N_REG-1:0][WIDTH-1:0]   word_data;
    logic [N_REG-1:0][WIDTH-1:0]   staging;
    logic [N_REG*WIDTH-1:0]        staging_flat;
    logic [DATA_WIDTH-1:0]         shadow_d;
    logic [DATA_WIDTH-1:0]         shadow;
    logic                          mask_full_next;
    logic                          start_pulse;
    logic                          clear_pulse;
    logic                          set_incomplete;
    logic                          set_overrun;

    for (genvar i = 0; i < N_REG; i++) begin : g_unpack
        assign word_we[i]   = reg_file_to_ip.spikes_input[i].qe;
        assign word_data[i] = reg_file_to_ip.spikes_input[i].q;
    end

    spiker_word_stager #(
        .WIDTH (WIDTH),
        .N_REG (N_REG),
        .CNT_W (CNT_W)
    ) u_stager (
        .clk            (clk_i),
        .rst            (rst_i),
        .word_we        (word_we),
        .word_data      (word_data),
        .load           (state == RD_LOAD),
        .staging        (staging),
        .mask_full_next (mask_full_next),
        .words_pending  (words_pending_o)
    );

    assign staging_flat = staging;

    // Padding bits past the last real spike are never forwarded to the core.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_shadow
        if (b < N_SPIKES) begin : g_spk
            assign shadow_d[b] = staging_flat[b];
        end else begin : g_pad
            assign shadow_d[b] = 1'b0;
        end
    end

    assign start_pulse    = reg_file_to_ip.start.qe && reg_file_to_ip.start.q;
    assign clear_pulse    = reg_file_to_ip.err_clear.qe && reg_file_to_ip.err_clear.q;
    assign set_incomplete = start_pulse && (state == RD_IDLE) && !mask_full_next;
    assign set_overrun    = start_pulse && (state != RD_IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= RD_IDLE;
            shadow           <= '0;
            data_valid_o     <= 1'b0;
            busy_o           <= 1'b0;
            err_incomplete_o <= 1'b0;
            err_overrun_o    <= 1'b0;
        end else begin
            // Setting events take priority over a same-cycle clear.
            err_incomplete_o <= set_incomplete || (err_incomplete_o && !clear_pulse);
            err_overrun_o    <= set_overrun || (err_overrun_o && !clear_pulse);
            case (state)
                RD_IDLE: begin
                    if (start_pulse && mask_full_next) begin
                        state  <= RD_LOAD;
                        busy_o <= 1'b1;
                    end
                end
                RD_LOAD: begin
                    shadow       <= shadow_d;
                    state        <= RD_SEND;
                    data_valid_o <= 1'b1;
                end
                RD_SEND: begin
                    if (core_ready_i) begin
                        state        <= RD_IDLE;
                        data_valid_o <= 1'b0;
                        busy_o       <= 1'b0;
                    end
                end
                default: begin
                    state        <= RD_IDLE;
                    data_valid_o <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

    assign data_in_o = shadow;

endmodule
